// File: rtl/serial_parallel_sync_pkg.sv
// Shared definitions for the serial-to-parallel synchroniser and its peers:
// the idle/alignment COMMA symbol, the default number of aligned commas
// needed to declare the link active, the FSM state encoding, and a helper
// that sizes the comma counter.
package serial_parallel_sync_pkg;

  // Idle symbol sent by the upstream serialiser whenever it has no data.
  localparam logic [7:0]  SP_COMMA      = 8'hBC;
  // Consecutive aligned COMMA words needed before the link is declared active.
  localparam int unsigned SP_ACTIVE_CNT = 32'd4;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_ALIGNED = 2'b01,
    ST_ACTIVE  = 2'b10
  } sp_state_e;

  // Width of a counter that must hold every value 0..n (never less than 1 bit).
  function automatic int unsigned sp_cnt_width(input int unsigned n);
    return (n < 32'd1) ? 32'd1 : $clog2(n + 32'd1);
  endfunction

endpackage

// File: rtl/serial_parallel_sync_comma_detect.sv
// sp_comma_detect: combinational compare of an 8-bit candidate word against
// the COMMA symbol.
//   word_i  [7:0] candidate word {shift[6:0], serial bit}
//   match_o       high when word_i equals COMMA
module sp_comma_detect
  import serial_parallel_sync_pkg::*;
#(
  parameter logic [7:0] COMMA = SP_COMMA
) (
  input  logic [7:0] word_i,
  output logic       match_o
);

  assign match_o = (word_i == COMMA);

endmodule

// File: rtl/serial_parallel_sync.sv
// serial_parallel_sync: recovers bytes from an MSB-first serial stream.
// A bit-level hunt looks for COMMA; once found, word boundaries are fixed and
// ACTIVE_CNT consecutive aligned COMMAs put the link into ACTIVE, where every
// non-COMMA word is presented as a registered parallel byte for 8 cycles.
// ACTIVE is only left through reset.
//   clk_SP        serial bit clock
//   reset_L       asynchronous active-low reset
//   data_in_SP    serial data, MSB of each byte first
//   data_out_SP   recovered byte (registered)
//   valid_out_SP  high while data_out_SP holds a non-COMMA byte received in ACTIVE
//   active_SP     high once synchronisation is achieved
module serial_parallel_sync
  import serial_parallel_sync_pkg::*;
#(
  parameter logic [7:0]  COMMA      = SP_COMMA,
  parameter int unsigned ACTIVE_CNT = SP_ACTIVE_CNT
) (
  input  logic       clk_SP,
  input  logic       reset_L,
  input  logic       data_in_SP,
  output logic [7:0] data_out_SP,
  output logic       valid_out_SP,
  output logic       active_SP
);

  localparam int unsigned          CNT_W   = sp_cnt_width(ACTIVE_CNT);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(ACTIVE_CNT);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

  // The candidate word only ever uses the seven newest stored bits; the
  // eighth bit of the byte-wide shift register would fall out unobserved,
  // so only seven are kept.
  logic [6:0]       shift_q,     shift_d;
  sp_state_e        state_q,     state_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             active_q,    active_d;

  logic [7:0]       cand_s;
  logic             comma_hit_s;
  logic             boundary_s;
  logic [CNT_W-1:0] comma_inc_s;

  assign cand_s     = {shift_q, data_in_SP};
  assign boundary_s = (bit_cnt_q == 3'd7);
  // Saturating increment: the counter parks at ACTIVE_CNT and never wraps.
  assign comma_inc_s = (comma_cnt_q == CNT_MAX) ? comma_cnt_q : (comma_cnt_q + CNT_ONE);

  sp_comma_detect #(
    .COMMA (COMMA)
  ) u_comma_detect (
    .word_i  (cand_s),
    .match_o (comma_hit_s)
  );

  // Next-state and next-output logic for the hunt/align/active FSM.
  always_comb begin
    shift_d     = cand_s[6:0];
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    active_d    = active_q;

    case (state_q)
      ST_SEARCH: begin
        bit_cnt_d = 3'd0;
        data_d    = 8'h00;
        valid_d   = 1'b0;
        active_d  = 1'b0;
        if (comma_hit_s) begin
          // This edge sampled the hunted COMMA's LSB, so the next bit is
          // the MSB of the following word: counter restarts at 0.
          comma_cnt_d = CNT_ONE;
          if (ACTIVE_CNT <= 32'd1) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d  = ST_ALIGNED;
          end
        end else begin
          comma_cnt_d = {CNT_W{1'b0}};
        end
      end

      ST_ALIGNED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        data_d    = 8'h00;
        valid_d   = 1'b0;
        active_d  = 1'b0;
        if (boundary_s) begin
          if (comma_hit_s) begin
            comma_cnt_d = comma_inc_s;
            if (comma_inc_s == CNT_MAX) begin
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
            end else begin
              state_d  = ST_ALIGNED;
            end
          end else begin
            // Misaligned or corrupted word: drop lock and hunt again.
            state_d     = ST_SEARCH;
            comma_cnt_d = {CNT_W{1'b0}};
          end
        end else begin
          state_d = ST_ALIGNED;
        end
      end

      ST_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        active_d  = 1'b1;
        if (boundary_s) begin
          if (comma_hit_s) begin
            valid_d = 1'b0;
          end else begin
            data_d  = cand_s;
            valid_d = 1'b1;
          end
        end else begin
          valid_d = valid_q;
        end
      end

      default: begin
        state_d     = ST_SEARCH;
        bit_cnt_d   = 3'd0;
        comma_cnt_d = {CNT_W{1'b0}};
        data_d      = 8'h00;
        valid_d     = 1'b0;
        active_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_SP or negedge reset_L) begin
    if (!reset_L) begin
      shift_q     <= 7'h00;
      state_q     <= ST_SEARCH;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= {CNT_W{1'b0}};
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
    end
  end

  assign data_out_SP  = data_q;
  assign valid_out_SP = valid_q;
  assign active_SP    = active_q;

endmodule

// File: tb/tb_serial_parallel_sync.sv
// Directed + randomized bench for serial_parallel_sync. A reference model
// tracks the received bit history and predicts outputs from absolute cycle
// numbers of word boundaries; every cycle is compared against it, plus
// explicit constant checks at the key protocol points.
module tb_serial_parallel_sync;

  localparam logic [7:0] COMMA_C = 8'hBC;
  localparam int         ACT_C   = 4;

  logic       clk_SP = 1'b0;
  logic       reset_L;
  logic       data_in_SP;
  logic [7:0] data_out_SP;
  logic       valid_out_SP;
  logic       active_SP;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         hist[$];
  int         mode;       // 0 hunting, 1 aligned, 2 active
  int         cyc;
  int         next_bnd;   // cycle number of the next word boundary
  int         ccnt;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_active;

  always #5 clk_SP = ~clk_SP;

  serial_parallel_sync #(
    .COMMA      (8'hBC),
    .ACTIVE_CNT (4)
  ) dut (
    .clk_SP       (clk_SP),
    .reset_L      (reset_L),
    .data_in_SP   (data_in_SP),
    .data_out_SP  (data_out_SP),
    .valid_out_SP (valid_out_SP),
    .active_SP    (active_SP)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    mode     = 0;
    cyc      = 0;
    next_bnd = 0;
    ccnt     = 0;
    m_data   = 8'h00;
    m_valid  = 1'b0;
    m_active = 1'b0;
  endtask

  task automatic model_step(input bit b);
    logic [7:0] w;
    int n;
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());
    cyc++;
    n = hist.size();
    w = 8'h00;
    // Last eight received bits, oldest first; missing ones read as zero.
    for (int k = 0; k < 8; k++) begin
      w = w << 1;
      if (k >= 8 - n) w[0] = hist[k - (8 - n)];
    end
    if (mode == 0) begin
      if (w == COMMA_C) begin
        ccnt     = 1;
        next_bnd = cyc + 8;
        if (ccnt >= ACT_C) begin
          mode = 2; m_active = 1'b1;
        end else begin
          mode = 1;
        end
      end
    end else if (cyc == next_bnd) begin
      next_bnd = cyc + 8;
      if (mode == 1) begin
        if (w == COMMA_C) begin
          ccnt++;
          if (ccnt >= ACT_C) begin
            mode = 2; m_active = 1'b1;
          end
        end else begin
          mode = 0; ccnt = 0;
        end
      end else begin
        if (w == COMMA_C) begin
          m_valid = 1'b0;
        end else begin
          m_data = w; m_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/data"},   data_out_SP,           m_data);
    chk({tag, "/valid"},  {7'd0, valid_out_SP},  {7'd0, m_valid});
    chk({tag, "/active"}, {7'd0, active_SP},     {7'd0, m_active});
  endtask

  // Drive one bit just after an edge, let the next edge sample it, compare.
  task automatic step(input bit b);
    data_in_SP = b;
    @(posedge clk_SP);
    #1;
    if (!reset_L) model_reset();
    else          model_step(b);
    check_outputs("cycle");
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step(b[i]);
  endtask

  initial begin
    logic [7:0] rb;
    model_reset();
    reset_L    = 1'b0;
    data_in_SP = 1'b0;
    #2;
    chk("reset_data",   data_out_SP,          8'h00);
    chk("reset_valid",  {7'd0, valid_out_SP}, 8'h00);
    chk("reset_active", {7'd0, active_SP},    8'h00);

    // Reset held with random serial data.
    for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)));
    reset_L = 1'b1;

    // Idle stream: link goes active on the LSB of the 4th COMMA.
    for (int i = 0; i < 3; i++) send_byte(COMMA_C);
    chk("active_after_3bc", {7'd0, active_SP}, 8'h00);
    send_byte(COMMA_C);
    chk("active_after_4bc", {7'd0, active_SP}, 8'h01);
    chk("valid_after_4bc",  {7'd0, valid_out_SP}, 8'h00);

    send_byte(8'hFF);
    chk("byte_ff", data_out_SP, 8'hFF);
    chk("valid_ff", {7'd0, valid_out_SP}, 8'h01);
    send_byte(8'h00);
    chk("byte_00", data_out_SP, 8'h00);
    chk("valid_00", {7'd0, valid_out_SP}, 8'h01);
    send_byte(8'hA5);
    chk("byte_a5", data_out_SP, 8'hA5);
    chk("valid_a5", {7'd0, valid_out_SP}, 8'h01);

    send_byte(8'h3C);
    chk("byte_3c", data_out_SP, 8'h3C);
    send_byte(COMMA_C);
    chk("hold_3c_data",  data_out_SP, 8'h3C);
    chk("hold_3c_valid", {7'd0, valid_out_SP}, 8'h00);

    // Random traffic mixing idle commas and data bytes.
    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) send_byte(COMMA_C);
      else                           send_byte(rb);
    end

    // Asynchronous reset mid-byte while active.
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)));
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    chk("async_rst_data",   data_out_SP,          8'h00);
    chk("async_rst_valid",  {7'd0, valid_out_SP}, 8'h00);
    chk("async_rst_active", {7'd0, active_SP},    8'h00);
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)));
    reset_L = 1'b1;

    // Junk bits, then a non-comma in ALIGNED forces a fresh hunt.
    step(1'b1); step(1'b1); step(1'b0);
    send_byte(COMMA_C);
    send_byte(COMMA_C);
    send_byte(8'h12);
    chk("active_after_12", {7'd0, active_SP}, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(COMMA_C);
    chk("active_after_3_fresh_bc", {7'd0, active_SP}, 8'h00);
    send_byte(COMMA_C);
    chk("active_after_4_fresh_bc", {7'd0, active_SP}, 8'h01);
    send_byte(8'h5A);
    chk("byte_5a", data_out_SP, 8'h5A);
    chk("valid_5a", {7'd0, valid_out_SP}, 8'h01);
    send_byte(COMMA_C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
